// File: rtl/unary_expander_14.sv
// -----------------------------------------------------------------------------
// unary_expander_14
// Turns a ones-count into an N-bit thermometer word (ones filled from bit 0
// upward) and streams that word out serially, bit 0 first, one bit per
// accepted beat. Valid/ready handshakes on both the count and the bit stream.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_count is valid
//   in_ready   expander takes a count this cycle
//   in_count   requested ones-count (CW bits), values above N saturate to N
//   word_out   thermometer word of the count being serialized (held in IDLE)
//   out_valid  ser_bit / ser_last are valid
//   out_ready  downstream accepts ser_bit this cycle
//   ser_bit    current serial bit
//   ser_last   high on the final (bit N-1) beat of a word
//   sat_err    sticky out-of-range-count flag
//
// Build option
//   SAT_FLAG_EN : when defined, sat_err latches high on any accepted
//                 in_count > N until reset; otherwise sat_err is tied low.
// -----------------------------------------------------------------------------
module unary_expander_14 #(
   parameter int N  = 14,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_count,
   output logic [N-1:0]  word_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          ser_bit,
   output logic          ser_last,
   output logic          sat_err
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   localparam logic [CW-1:0] MAX_CNT  = CW'(N);
   localparam logic [CW-1:0] LAST_BT  = CW'(N - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] beat;
   logic [CW-1:0] beat_inc;
   logic [CW-1:0] cap_cnt;
   logic          last_fire;
   logic          take;

   // Thermometer word with the low c bits set.
   function automatic logic [N-1:0] therm(input logic [CW-1:0] c);
      logic [N-1:0] w;
      for (int i = 0; i < N; i++) begin
         w[i] = (CW'(i) < c);
      end
      return w;
   endfunction

   // Handshake decode: a new count is taken in IDLE, or in the same cycle the
   // last beat of the current word is accepted so words stream without a bubble.
   always_comb begin
      beat_inc  = beat + CW'(1);
      cap_cnt   = (in_count > MAX_CNT) ? MAX_CNT : in_count;
      last_fire = (state == EMIT) && (beat == LAST_BT) && out_ready;
      if (!rst_n) begin
         in_ready = 1'b0;
      end else begin
         in_ready = (state == IDLE) || last_fire;
      end
      take = in_valid && in_ready;
   end

   // Control FSM with registered stream outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         beat      <= '0;
         word_out  <= '0;
         out_valid <= 1'b0;
         ser_bit   <= 1'b0;
         ser_last  <= 1'b0;
      end else if (take) begin
         // Load a new word; beat 0 is never the last beat since N > 1.
         state     <= EMIT;
         cnt       <= cap_cnt;
         beat      <= '0;
         word_out  <= therm(cap_cnt);
         out_valid <= 1'b1;
         ser_bit   <= (cap_cnt != CW'(0));
         ser_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               ser_bit   <= 1'b0;
               ser_last  <= 1'b0;
            end
            EMIT: begin
               if (out_ready) begin
                  if (beat == LAST_BT) begin
                     state     <= IDLE;
                     beat      <= '0;
                     out_valid <= 1'b0;
                     ser_bit   <= 1'b0;
                     ser_last  <= 1'b0;
                  end else begin
                     beat     <= beat_inc;
                     ser_bit  <= (beat_inc < cnt);
                     ser_last <= (beat_inc == LAST_BT);
                  end
               end else begin
                  beat <= beat;
               end
            end
            default: begin
               state     <= IDLE;
               beat      <= '0;
               out_valid <= 1'b0;
               ser_bit   <= 1'b0;
               ser_last  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SAT_FLAG_EN
   logic sat_q;

   // Sticky flag for an accepted out-of-range count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else if (take && (in_count > MAX_CNT)) begin
         sat_q <= 1'b1;
      end else begin
         sat_q <= sat_q;
      end
   end

   assign sat_err = sat_q;
`else
   assign sat_err = 1'b0;
`endif

endmodule
